// File: rtl/addsub_multiword_seq.sv
// Multi-word add/subtract sequencer: runs WORDS*32-bit operands through one shared
// 32-bit adder, least-significant word first, chaining carry/borrow between words.

module AddSub32bFlag (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Ci,
   input  logic        Ctrl,
   output logic [31:0] S,
   output logic        CF,
   output logic        OF,
   output logic        ZF,
   output logic        SF,
   output logic        PF
);
   logic [31:0] b_eff;
   logic        c_eff;
   logic [32:0] sum;

   // Subtract is A + ~B + ~Ci; the raw carry-out is inverted so CF reads as a borrow.
   always_comb begin
      b_eff = Ctrl ? ~B : B;
      c_eff = Ctrl ? ~Ci : Ci;
      sum   = {1'b0, A} + {1'b0, b_eff} + {32'b0, c_eff};
      S     = sum[31:0];
      CF    = sum[32] ^ Ctrl;
      OF    = (A[31] == b_eff[31]) && (sum[31] != A[31]);
      ZF    = (sum[31:0] == 32'b0);
      SF    = sum[31];
      PF    = ^sum[31:0];
   end
endmodule

module addsub_multiword_seq #(
   parameter int WORDS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [32*WORDS-1:0] A,
   input  logic [32*WORDS-1:0] B,
   input  logic                Ci,
   input  logic                Ctrl,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*WORDS-1:0] S,
   output logic                CF,
   output logic                OF,
   output logic                ZF,
   output logic                SF,
   output logic                PF,
   output logic                busy
);
   localparam int W  = 32 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, work_q, work_d, s_q, s_d;
   logic          ctrl_q, ctrl_d, chain_q, chain_d;
   logic          zf_acc_q, zf_acc_d, pf_acc_q, pf_acc_d;
   logic          cf_q, cf_d, of_q, of_d, zf_q, zf_d, sf_q, sf_d, pf_q, pf_d;

   logic [31:0]   add_a, add_b, add_s;
   logic          add_cf, add_of, add_zf, add_sf, add_pf;
   logic          last;

   assign add_a = a_q[32*idx_q +: 32];
   assign add_b = b_q[32*idx_q +: 32];
   assign last  = (idx_q == IW'(WORDS - 1));

   AddSub32bFlag u_adder (
      .A    (add_a),
      .B    (add_b),
      .Ci   (chain_q),
      .Ctrl (ctrl_q),
      .S    (add_s),
      .CF   (add_cf),
      .OF   (add_of),
      .ZF   (add_zf),
      .SF   (add_sf),
      .PF   (add_pf)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      s_d      = s_q;
      ctrl_d   = ctrl_q;
      chain_d  = chain_q;
      zf_acc_d = zf_acc_q;
      pf_acc_d = pf_acc_q;
      cf_d     = cf_q;
      of_d     = of_q;
      zf_d     = zf_q;
      sf_d     = sf_q;
      pf_d     = pf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d  = RUN;
               a_d      = A;
               b_d      = B;
               ctrl_d   = Ctrl;
               chain_d  = Ci;
               idx_d    = '0;
               zf_acc_d = 1'b1;
               pf_acc_d = 1'b0;
            end
         end
         RUN: begin
            work_d[32*idx_q +: 32] = add_s;
            chain_d  = add_cf;
            zf_acc_d = zf_acc_q & add_zf;
            pf_acc_d = pf_acc_q ^ add_pf;
            // The visible result and flags only change when the last word lands.
            if (last) begin
               state_d = DONE;
               s_d     = work_q;
               s_d[32*idx_q +: 32] = add_s;
               cf_d    = add_cf;
               of_d    = add_of;
               sf_d    = add_sf;
               zf_d    = zf_acc_q & add_zf;
               pf_d    = pf_acc_q ^ add_pf;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         s_q      <= '0;
         ctrl_q   <= 1'b0;
         chain_q  <= 1'b0;
         zf_acc_q <= 1'b1;
         pf_acc_q <= 1'b0;
         cf_q     <= 1'b0;
         of_q     <= 1'b0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
         pf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         work_q   <= work_d;
         s_q      <= s_d;
         ctrl_q   <= ctrl_d;
         chain_q  <= chain_d;
         zf_acc_q <= zf_acc_d;
         pf_acc_q <= pf_acc_d;
         cf_q     <= cf_d;
         of_q     <= of_d;
         zf_q     <= zf_d;
         sf_q     <= sf_d;
         pf_q     <= pf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign S         = s_q;
   assign CF        = cf_q;
   assign OF        = of_q;
   assign ZF        = zf_q;
   assign SF        = sf_q;
   assign PF        = pf_q;
endmodule
